// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline: ALU operation codes and
// operand-forwarding select encodings.
package riscv_pkg;

    // ALU operation encodings; 4'b1010..4'b1111 are unused and yield 0.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Forward-select encodings; 2'b11 falls back to the register file.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU. Arithmetic wraps modulo 2^XLEN, shift amount is
// b[4:0], unused operation codes produce 0 so nothing X ever leaves here.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [4:0] w_shamt;
    assign w_shamt = b[4:0];

    // Select the operation result; default covers the unused codes.
    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_SLL:  result = a << w_shamt;
            ALU_SRL:  result = a >> w_shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> w_shamt);
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch
// target / PC-select for fetch, and the EX/MEM pipeline register.
// E-side outputs are purely combinational; *M outputs are registered.
module execute_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ExtImmE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [4:0]      Rs1E,
    input  logic [4:0]      Rs2E,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            PCSrcE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUOutM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            ZeroE;

    // Source indices only matter to the hazard unit; they are consumed here
    // solely so the port list stays uniform across stages.
    logic w_unused_rs;
    assign w_unused_rs = ^{Rs1E, Rs2E};

    // rs1 forwarding mux: newest value wins (MEM over WB over register file).
    always_comb begin
        SrcAE = RD1E;
        case (ForwardAE)
            FWD_WB:  SrcAE = ResultW;
            FWD_MEM: SrcAE = ALUResultM;
            default: SrcAE = RD1E;
        endcase
    end

    // rs2 forwarding mux; its output doubles as the store data.
    always_comb begin
        WriteDataE = RD2E;
        case (ForwardBE)
            FWD_WB:  WriteDataE = ResultW;
            FWD_MEM: WriteDataE = ALUResultM;
            default: WriteDataE = RD2E;
        endcase
    end

    assign SrcBE = ALUSrcE ? ExtImmE : WriteDataE;

    alu #(.XLEN(XLEN)) u_alu (
        .a      (SrcAE),
        .b      (SrcBE),
        .ctrl   (ALUControlE),
        .result (ALUResultE),
        .zero   (ZeroE)
    );

    // Branch/jump target is always PC-relative; jalr fixup happens elsewhere.
    assign PCTargetE = PCE + ExtImmE;
    assign PCSrcE    = JumpE | (BranchE & ZeroE);

    // EX/MEM register: reset clears everything, otherwise capture every edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            RdM        <= 5'd0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RdM        <= RdE;
            ALUOutM    <= ALUResultE;
            WriteDataM <= WriteDataE;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases followed by randomized traffic
// compared against a behavioural model of the EX stage.
module tb_execute_stage;

    localparam int W = 105;   // packed expected EX/MEM contents

    logic        clk;
    logic        reset;
    logic        JumpE, BranchE, ALUSrcE;
    logic [3:0]  ALUControlE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] PCE, ExtImmE, RD1E, RD2E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [31:0] ALUResultM, ResultW;
    logic        RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE;
    logic [31:0] PCPlus4E;
    logic [31:0] ALUResultE, WriteDataE, PCTargetE;
    logic        PCSrcE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUOutM, WriteDataM, PCPlus4M;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    execute_stage dut (
        .clk(clk), .reset(reset), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .PCE(PCE), .ExtImmE(ExtImmE), .RD1E(RD1E), .RD2E(RD2E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ALUResultM(ALUResultM), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .PCPlus4E(PCPlus4E),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .PCTargetE(PCTargetE), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RdM(RdM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_fwd(input logic [1:0] sel,
        input logic [31:0] rf, input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return rf;
    endfunction

    function automatic longint as_signed(input logic [31:0] v);
        return v[31] ? longint'(v) - 64'sh1_0000_0000 : longint'(v);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
        input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb, p, q, mask;
        int sh;
        ua = longint'(a); ub = longint'(b);
        sa = as_signed(a); sb = as_signed(b);
        mask = 64'hFFFF_FFFF;
        sh = int'(b % 32);
        p = 1;
        for (int i = 0; i < sh; i++) p = p * 2;
        case (op)
            4'd0: return 32'((ua + ub) & mask);
            4'd1: return 32'((ua - ub) & mask);
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return (sa < sb) ? 32'd1 : 32'd0;
            4'd6: return (ua < ub) ? 32'd1 : 32'd0;
            4'd7: return 32'((ua * p) & mask);
            4'd8: return 32'(ua / p);
            4'd9: begin
                if (sa >= 0) q = sa / p;
                else q = -((-sa + p - 1) / p);
                return 32'(q & mask);
            end
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Check the combinational E outputs, queue the expected EX/MEM contents,
    // clock once (with reset = rst) and compare the registered outputs.
    task automatic step(input string tag, input logic rst);
        logic [31:0] a, wd, bsrc, res, tgt;
        logic        pcsrc;
        logic [W-1:0] e;
        reset = rst;
        #1;
        a     = ref_fwd(ForwardAE, RD1E, ResultW, ALUResultM);
        wd    = ref_fwd(ForwardBE, RD2E, ResultW, ALUResultM);
        bsrc  = ALUSrcE ? ExtImmE : wd;
        res   = ref_alu(ALUControlE, a, bsrc);
        tgt   = 32'((longint'(PCE) + longint'(ExtImmE)) % 64'h1_0000_0000);
        pcsrc = JumpE || (BranchE && res == 32'd0);
        check_eq({tag, ".alu"},  ALUResultE, res);
        check_eq({tag, ".wd"},   WriteDataE, wd);
        check_eq({tag, ".tgt"},  PCTargetE, tgt);
        check_eq({tag, ".pcs"},  {31'd0, PCSrcE}, {31'd0, pcsrc});
        check_eq({tag, ".zero"}, {31'd0, dut.ZeroE}, {31'd0, res == 32'd0});
        if (rst) e = '0;
        else e = {RegWriteE, MemWriteE, ResultSrcE, RdE, res, wd, PCPlus4E};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;
        e = exp_q.pop_front();
        check_eq({tag, ".rwM"}, {31'd0, RegWriteM}, {31'd0, e[104]});
        check_eq({tag, ".mwM"}, {31'd0, MemWriteM}, {31'd0, e[103]});
        check_eq({tag, ".rsM"}, {30'd0, ResultSrcM}, {30'd0, e[102:101]});
        check_eq({tag, ".rdM"}, {27'd0, RdM}, {27'd0, e[100:96]});
        check_eq({tag, ".aluM"}, ALUOutM, e[95:64]);
        check_eq({tag, ".wdM"}, WriteDataM, e[63:32]);
        check_eq({tag, ".pc4M"}, PCPlus4M, e[31:0]);
        // inputs unchanged across the edge, so E outputs must be too
        check_eq({tag, ".aluE_hold"}, ALUResultE, res);
    endtask

    task automatic drive_random();
        logic [31:0] pool[4];
        pool[0] = 32'h8000_0000; pool[1] = 32'hFFFF_FFFF;
        pool[2] = 32'd0;         pool[3] = 32'd1;
        JumpE       = ($urandom_range(0, 7) == 0);
        BranchE     = $urandom_range(0, 1);
        ALUSrcE     = $urandom_range(0, 1);
        ALUControlE = 4'($urandom_range(0, 15));
        ForwardAE   = 2'($urandom_range(0, 3));
        ForwardBE   = 2'($urandom_range(0, 3));
        PCE         = $urandom;
        ExtImmE     = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
        RD1E        = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
        RD2E        = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
        ALUResultM  = $urandom;
        ResultW     = ($urandom_range(0, 3) == 0) ? ALUResultM : $urandom;
        Rs1E        = 5'($urandom); Rs2E = 5'($urandom); RdE = 5'($urandom);
        RegWriteE   = $urandom_range(0, 1);
        MemWriteE   = $urandom_range(0, 1);
        ResultSrcE  = 2'($urandom_range(0, 3));
        PCPlus4E    = $urandom;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        JumpE = 0; BranchE = 0; ALUSrcE = 1; ALUControlE = 4'b0000;
        ForwardAE = 2'b00; ForwardBE = 2'b00;
        PCE = 32'h24; ExtImmE = 32'd2; RD1E = 32'd7; RD2E = 32'h5555;
        Rs1E = 5'd1; Rs2E = 5'd2; RdE = 5'd3;
        ALUResultM = 32'hCC; ResultW = 32'h58;
        RegWriteE = 1; MemWriteE = 0; ResultSrcE = 2'b00; PCPlus4E = 32'h28;

        // reset state of the EX/MEM register
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst.aluM", ALUOutM, 32'd0);
        check_eq("rst.rdM", {27'd0, RdM}, 32'd0);
        check_eq("rst.rwM", {31'd0, RegWriteM}, 32'd0);
        reset = 1'b0;

        // 1 + 5: add 7+2, then the pipe captures it
        check_eq("t1.alu_lit", ALUResultE, 32'd9);
        check_eq("t1.tgt_lit", PCTargetE, 32'h26);
        step("t1", 1'b0);
        check_eq("t5.aluM_lit", ALUOutM, 32'd9);
        check_eq("t5.wdM_lit", WriteDataM, 32'h5555);

        // 2: forwarding from MEM and WB
        ForwardAE = 2'b10; #1;
        check_eq("t2.mem_lit", ALUResultE, 32'hCE);
        step("t2a", 1'b0);
        ForwardAE = 2'b01; #1;
        check_eq("t2.wb_lit", ALUResultE, 32'h5A);
        step("t2b", 1'b0);

        // 3: zero result drives branch, then jump
        ForwardAE = 2'b00; ForwardBE = 2'b10; ALUSrcE = 0;
        ALUControlE = 4'b0001; RD1E = 32'hCC; BranchE = 1; #1;
        check_eq("t3.pcs_lit", {31'd0, PCSrcE}, 32'd1);
        step("t3a", 1'b0);
        BranchE = 0; JumpE = 1;
        step("t3b", 1'b0);
        JumpE = 0;

        // 4: ALU boundary sweep
        ForwardBE = 2'b00; ALUSrcE = 1;
        RD1E = 32'hFFFF_FFFF; ExtImmE = 32'd1;
        ALUControlE = 4'b0101; #1;
        check_eq("t4.slt_lit", ALUResultE, 32'd1);
        step("t4slt", 1'b0);
        ALUControlE = 4'b0110; step("t4sltu", 1'b0);
        RD1E = 32'h8000_0000; ExtImmE = 32'd4;
        ALUControlE = 4'b1001; #1;
        check_eq("t4.sra_lit", ALUResultE, 32'hF800_0000);
        step("t4sra", 1'b0);
        ALUControlE = 4'b1000; step("t4srl", 1'b0);
        ALUControlE = 4'b1111; step("t4nop", 1'b0);

        // 6: reset with nonzero inputs, then capture resumes
        ALUControlE = 4'b0000; RD1E = 32'd7; ExtImmE = 32'd2;
        MemWriteE = 1; ResultSrcE = 2'b10;
        step("t6rst", 1'b1);
        step("t6resume", 1'b0);

        // randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            drive_random();
            step("rnd", ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
